// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM states, transfer packet and constants for the APB memory slave
package apb_pkg;
  localparam int PKT_ADDR_W = 16;
  localparam int PKT_DATA_W = 32;
  localparam int STRB_W = PKT_DATA_W / 8;
  localparam logic [15:0] ERRCNT_MAX = 16'hFFFF;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef struct packed {
    logic [PKT_ADDR_W-1:0] addr;
    logic                  write;
    logic [PKT_DATA_W-1:0] data;
    logic [STRB_W-1:0]     strb;
  } apb_pkt_t;
endpackage

// File: rtl/apb_mem_array.sv
// apb_mem_array: byte-laned DEPTH x DATA_W storage, cleared asynchronously on reset
module apb_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic                we,
  input  logic [DATA_W/8-1:0] strb,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [AW-1:0]       raddr,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk or negedge Rst)
    if (!Rst) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (we) for (int b = 0; b < DATA_W/8; b++) if (strb[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB memory target with wait states, byte strobes, range errors and abort
module apb_mem_slave import apb_pkg::*; #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic                PSel,
  input  logic                PEnable,
  input  logic                PWrite,
  input  logic [ADDR_W-1:0]   PAddr,
  input  logic [DATA_W-1:0]   PWData,
  input  logic [DATA_W/8-1:0] PStrb,
  output logic [DATA_W-1:0]   PRData,
  output logic                PReady,
  output logic                PSlvErr,
  output logic [15:0]         ErrCnt
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic write_q, write_d, err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d, rdata_q, rdata_d, mem_rdata;
  logic [DATA_W/8-1:0] strb_q, strb_d;
  logic ready_q, ready_d, slverr_q, slverr_d;
  logic [15:0] errcnt_q, errcnt_d;
  logic setup, fire, we;
  assign setup = PSel && !PEnable;
  assign fire = state_q == ACCESS && PSel && PEnable && cnt_q == 4'd0;
  assign we = fire && write_q && !err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    write_d = write_q;
    data_d = data_q;
    strb_d = strb_q;
    err_d = err_q;
    rdata_d = rdata_q;
    errcnt_d = errcnt_q;
    ready_d = 1'b0;
    slverr_d = 1'b0;
    if (state_q != ACCESS && setup) begin
      state_d = ACCESS;
      cnt_d = 4'(WAIT_STATES);
      addr_d = PAddr[AW-1:0];
      write_d = PWrite;
      data_d = PWData;
      strb_d = PStrb;
      err_d = 32'(PAddr) >= 32'(DEPTH);
    end else if (state_q == DONE || (state_q == ACCESS && !PSel)) begin
      state_d = IDLE;
    end else if (state_q == ACCESS && PEnable) begin
      cnt_d = cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
      state_d = fire ? DONE : state_q;
      ready_d = fire;
      slverr_d = fire && err_q;
      rdata_d = !fire ? rdata_q : err_q ? '0 : write_q ? rdata_q : mem_rdata;
      errcnt_d = fire && err_q && errcnt_q != ERRCNT_MAX ? errcnt_q + 16'd1 : errcnt_q;
    end
  end
  always_ff @(posedge clk or negedge Rst)
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      write_q <= 1'b0;
      data_q <= '0;
      strb_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
      errcnt_q <= '0;
      ready_q <= 1'b0;
      slverr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      write_q <= write_d;
      data_q <= data_d;
      strb_q <= strb_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      errcnt_q <= errcnt_d;
      ready_q <= ready_d;
      slverr_q <= slverr_d;
    end
  apb_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk), .Rst(Rst), .we(we), .strb(strb_q), .waddr(addr_q),
    .wdata(data_q), .raddr(addr_q), .rdata(mem_rdata)
  );
  assign PRData = rdata_q;
  assign PReady = ready_q;
  assign PSlvErr = slverr_q;
  assign ErrCnt = errcnt_q;
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: three slaves (0, 3, 2 wait states) checked against a word-array memory model
module tb_apb_mem_slave;
  import apb_pkg::*;
  localparam int WS [3] = '{0, 3, 2};
  logic clk = 0, Rst = 1;
  logic psel [3], penable [3], pwrite [3], pready [3], pslverr [3];
  logic [15:0] paddr [3], errcnt [3];
  logic [31:0] pwdata [3], prdata [3];
  logic [3:0] pstrb [3];
  logic [31:0] mdl_mem [3][256];
  logic [31:0] mdl_prd [3];
  logic [15:0] mdl_ecnt [3];
  int ntests = 0, nfail = 0;
  always #5 clk = ~clk;
  apb_mem_slave #(.WAIT_STATES(0)) u0 (.clk(clk), .Rst(Rst), .PSel(psel[0]), .PEnable(penable[0]),
    .PWrite(pwrite[0]), .PAddr(paddr[0]), .PWData(pwdata[0]), .PStrb(pstrb[0]), .PRData(prdata[0]),
    .PReady(pready[0]), .PSlvErr(pslverr[0]), .ErrCnt(errcnt[0]));
  apb_mem_slave #(.WAIT_STATES(3)) u1 (.clk(clk), .Rst(Rst), .PSel(psel[1]), .PEnable(penable[1]),
    .PWrite(pwrite[1]), .PAddr(paddr[1]), .PWData(pwdata[1]), .PStrb(pstrb[1]), .PRData(prdata[1]),
    .PReady(pready[1]), .PSlvErr(pslverr[1]), .ErrCnt(errcnt[1]));
  apb_mem_slave #(.WAIT_STATES(2)) u2 (.clk(clk), .Rst(Rst), .PSel(psel[2]), .PEnable(penable[2]),
    .PWrite(pwrite[2]), .PAddr(paddr[2]), .PWData(pwdata[2]), .PStrb(pstrb[2]), .PRData(prdata[2]),
    .PReady(pready[2]), .PSlvErr(pslverr[2]), .ErrCnt(errcnt[2]));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 256; i++) mdl_mem[k][i] = '0;
      mdl_prd[k] = '0;
      mdl_ecnt[k] = '0;
    end
  endtask

  task automatic run(int k, apb_pkt_t p, output logic [31:0] rd);
    int n;
    bit e;
    @(negedge clk);
    psel[k] = 1; penable[k] = 0; pwrite[k] = p.write; paddr[k] = p.addr; pwdata[k] = p.data; pstrb[k] = p.strb;
    @(negedge clk);
    penable[k] = 1; paddr[k] = ~p.addr; pwdata[k] = ~p.data;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!pready[k] && n < 40);
    e = p.addr >= 16'd256;
    if (e) begin
      mdl_prd[k] = '0;
      if (mdl_ecnt[k] != 16'hFFFF) mdl_ecnt[k]++;
    end else if (p.write) begin
      for (int i = 0; i < 4; i++) if (p.strb[i]) mdl_mem[k][p.addr[7:0]][8*i +: 8] = p.data[8*i +: 8];
    end else mdl_prd[k] = mdl_mem[k][p.addr[7:0]];
    chk($sformatf("dut%0d ready_cycle a=%h", k, p.addr), n, WS[k] + 1);
    chk($sformatf("dut%0d slverr a=%h", k, p.addr), 32'(pslverr[k]), 32'(e));
    chk($sformatf("dut%0d prdata a=%h", k, p.addr), prdata[k], mdl_prd[k]);
    chk($sformatf("dut%0d errcnt", k), 32'(errcnt[k]), 32'(mdl_ecnt[k]));
    rd = prdata[k];
  endtask

  typedef struct {apb_pkt_t p; bit rdchk; logic [31:0] exp;} vec_t;
  vec_t tbl [13];
  logic [31:0] rd;
  apb_pkt_t rp;
  bit seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      psel[k] = 0; penable[k] = 0; pwrite[k] = 0; paddr[k] = 0; pwdata[k] = 0; pstrb[k] = 0;
    end
    mdl_reset();
    #3 Rst = 0;
    #100;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset dut%0d outputs", k), {prdata[k] | {errcnt[k], 14'd0, pready[k], pslverr[k]}}, 32'd0);
    end
    @(negedge clk) Rst = 1;

    tbl[0]  = '{'{16'h50, 1, 32'h50, 4'hF}, 0, 0};
    tbl[1]  = '{'{16'h50, 0, 32'h0, 4'hF}, 1, 32'h50};
    tbl[2]  = '{'{16'h20, 1, 32'hAABBCCDD, 4'hF}, 0, 0};
    tbl[3]  = '{'{16'h20, 1, 32'h11223344, 4'b0101}, 0, 0};
    tbl[4]  = '{'{16'h20, 0, 32'h0, 4'h0}, 1, 32'hAA22CC44};
    tbl[5]  = '{'{16'h100, 1, 32'h1, 4'hF}, 1, 32'h0};
    tbl[6]  = '{'{16'h100, 0, 32'h0, 4'hF}, 1, 32'h0};
    tbl[7]  = '{'{16'h0, 0, 32'h0, 4'hF}, 1, 32'h0};
    tbl[8]  = '{'{16'h21, 1, 32'h12345678, 4'h0}, 0, 0};
    tbl[9]  = '{'{16'h21, 0, 32'h0, 4'hF}, 1, 32'h0};
    tbl[10] = '{'{16'hFF, 1, 32'hCAFEF00D, 4'hF}, 0, 0};
    tbl[11] = '{'{16'hFF, 0, 32'h0, 4'hF}, 1, 32'hCAFEF00D};
    tbl[12] = '{'{16'h50, 0, 32'h0, 4'h0}, 1, 32'h50};
    for (int i = 0; i < 13; i++) begin
      run(0, tbl[i].p, rd);
      if (tbl[i].rdchk) chk($sformatf("table[%0d] rdata", i), rd, tbl[i].exp);
    end
    chk("errcnt after two errors", 32'(errcnt[0]), 32'd2);

    @(negedge clk) force u0.errcnt_q = 16'hFFFE;
    @(negedge clk) release u0.errcnt_q;
    mdl_ecnt[0] = 16'hFFFE;
    chk("errcnt preset", 32'(errcnt[0]), 32'hFFFE);
    run(0, '{16'h1234, 1, 32'h9, 4'hF}, rd);
    run(0, '{16'h1235, 0, 32'h0, 4'hF}, rd);
    chk("errcnt saturated", 32'(errcnt[0]), 32'hFFFF);

    run(1, '{16'h10, 1, 32'hDEADBEEF, 4'hF}, rd);
    run(1, '{16'h10, 0, 32'h0, 4'hF}, rd);
    chk("ws3 readback", rd, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("ready drops after done", {31'd0, pready[1] | pslverr[1]}, 32'd0);
    for (int i = 0; i < 50; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      rp.addr = r < 2 ? 16'(256 + $urandom_range(0, 3)) : r == 2 ? 16'hFF : 16'($urandom_range(16, 23));
      rp.write = 1'($urandom);
      rp.data = $urandom;
      rp.strb = 4'($urandom);
      run(1, rp, rd);
    end

    @(negedge clk);
    psel[2] = 1; penable[2] = 0; pwrite[2] = 1; paddr[2] = 16'h30; pwdata[2] = 32'h5; pstrb[2] = 4'hF;
    @(negedge clk) penable[2] = 1;
    seen = 0;
    @(posedge clk); #1 seen |= pready[2];
    @(negedge clk) psel[2] = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1 seen |= pready[2]; end
    chk("abort no ready", 32'(seen), 32'd0);
    penable[2] = 0;
    run(2, '{16'h30, 0, 32'h0, 4'hF}, rd);
    chk("abort no write", rd, 32'h0);
    run(2, '{16'h30, 1, 32'h7, 4'hF}, rd);
    run(2, '{16'h30, 0, 32'h0, 4'hF}, rd);
    chk("after abort b2b", rd, 32'h7);
    chk("abort errcnt", 32'(errcnt[2]), 32'd0);

    @(negedge clk);
    psel[1] = 1; penable[1] = 0; pwrite[1] = 0; paddr[1] = 16'h10; pstrb[1] = 4'hF;
    @(negedge clk) penable[1] = 1;
    @(posedge clk); #2 Rst = 0;
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("async reset dut%0d", k), {prdata[k] | {errcnt[k], 14'd0, pready[k], pslverr[k]}}, 32'd0);
    psel[1] = 0; penable[1] = 0;
    mdl_reset();
    @(negedge clk) Rst = 1;
    run(0, '{16'h50, 0, 32'h0, 4'hF}, rd);
    chk("post reset 0x50", rd, 32'h0);
    run(0, '{16'h20, 0, 32'h0, 4'hF}, rd);
    chk("post reset 0x20", rd, 32'h0);
    run(1, '{16'h10, 0, 32'h0, 4'hF}, rd);
    chk("post reset 0x10", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
